// File: rtl/ZionDataType.sv
// Shared datapath types and default sizing for the execution-result path.
package ZionDataType;

  localparam int INPUTNUM_DEF = 7;
  localparam int BITWIDTH_DEF = 32;

  typedef logic [BITWIDTH_DEF-1:0] CpuType;

endpackage

// File: rtl/ex_res_rr_arb.sv
// Request arbiter for execution-result channels: fixed priority (lowest index)
// or round-robin from a rotating pointer. Produces one-hot grant plus binary index.
module ex_res_rr_arb
  import ZionDataType::*;
#(
  parameter int INPUTNUM = INPUTNUM_DEF,
  parameter int RRMODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [INPUTNUM-1:0]         i_req,
  input  logic                        i_en,
  output logic [INPUTNUM-1:0]         o_gnt,
  output logic [$clog2(INPUTNUM)-1:0] o_idx,
  output logic                        o_any
);

  localparam int            IW    = $clog2(INPUTNUM);
  localparam logic [IW:0]   N_EXT = (IW+1)'(INPUTNUM);
  localparam logic [IW-1:0] LAST  = IW'(INPUTNUM - 1);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_slot;
  logic [IW:0]   w_sum;
  logic          w_found;

  // Fixed priority is a round-robin search whose starting point never moves.
  assign w_base = (RRMODE != 0) ? r_ptr : '0;

  // Search downward in offset so the last hit kept is the nearest one to the base.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_slot  = '0;
    for (int k = INPUTNUM - 1; k >= 0; k--) begin
      w_sum   = {1'b0, w_base} + (IW+1)'(k);
      w_slot  = (w_sum >= N_EXT) ? IW'(w_sum - N_EXT) : w_sum[IW-1:0];
      w_found = w_found | i_req[w_slot];
      w_idx   = i_req[w_slot] ? w_slot : w_idx;
    end
  end

  assign o_any = w_found & i_en;
  assign o_idx = w_idx;

  // One-hot grant decode of the winning index.
  always_comb begin
    o_gnt = '0;
    for (int k = 0; k < INPUTNUM; k++) begin
      o_gnt[k] = o_any & (w_idx == IW'(k));
    end
  end

  // Pointer moves just past the winner on every grant and wraps at INPUTNUM-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (w_idx == LAST) ? '0 : (w_idx + IW'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/ex_res_arbiter.sv
// Execution-result arbiter: selects one ready source per cycle into a single
// registered writeback slot and counts contended cycles.
module ex_res_arbiter
  import ZionDataType::*;
#(
  parameter int INPUTNUM = INPUTNUM_DEF,
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int RRMODE   = 1,
  parameter int CNTW     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTNUM-1:0]          iValid,
  input  logic [INPUTNUM*BITWIDTH-1:0] iRes,
  output logic [INPUTNUM-1:0]          oReady,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [BITWIDTH-1:0]          oRes,
  output logic [$clog2(INPUTNUM)-1:0]  oSrc,
  output logic [CNTW-1:0]              oConflictCnt
);

  localparam int IW = $clog2(INPUTNUM);

  logic                w_load;
  logic                w_en;
  logic                w_any;
  logic                w_conflict;
  logic [INPUTNUM-1:0] w_gnt;
  logic [IW-1:0]       w_idx;
  logic [BITWIDTH-1:0] w_res;

  logic                r_valid;
  logic [BITWIDTH-1:0] r_res;
  logic [IW-1:0]       r_src;
  logic [CNTW-1:0]     r_cnt;

  // Slot can take a new result when empty or being drained this cycle;
  // no grants are offered while reset is held.
  assign w_load = ~r_valid | iReady;
  assign w_en   = w_load & rst_n;

  ex_res_rr_arb #(
    .INPUTNUM (INPUTNUM),
    .RRMODE   (RRMODE)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (iValid),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // AND-OR payload mux driven by the one-hot grant.
  always_comb begin
    w_res = '0;
    for (int k = 0; k < INPUTNUM; k++) begin
      w_res = w_res | ({BITWIDTH{w_gnt[k]}} & iRes[k*BITWIDTH +: BITWIDTH]);
    end
  end

  assign w_conflict = ($countones(iValid) > 1) | ((|iValid) & ~w_load);

  // Output slot: load on grant, empty on an idle load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_src   <= '0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_res   <= w_res;
      r_src   <= w_idx;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign oReady       = w_gnt;
  assign oValid       = r_valid;
  assign oRes         = r_res;
  assign oSrc         = r_src;
  assign oConflictCnt = r_cnt;

endmodule
